fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the program counter/instruction memory and the decode stage. It buffers up to DEPTH fetched {pc, instruction} pairs so that fetch keeps running while decode stalls for a few cycles. It is flushed when a redirect happens (branch, jump, or exception). Each entry is presented to decode with its PC and PC+4.

## Interface
- B, 32, address width (matches program counter width)
- W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all entries and any push in the same cycle
- in_valid  input  1  fetch presents a valid pair
- in_ready  output  1  queue accepts a pair this cycle
- in_pc  input  B  address of fetched instruction (program counter output)
- in_instr  input  W  fetched instruction word
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  B  PC of head entry
- out_pc_plus4  output  B  out_pc + 4
- out_instr  output  W  head instruction
- count  output  $clog2(DEPTH+1)  number of stored entries

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < DEPTH) && !reset. A push into a full queue is impossible; if in_valid is high while in_ready is low, the producer must hold the pair.
- A simultaneous push and pop when 0 < count < DEPTH leaves count unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- out_valid = (count != 0), except for bypass (see Configuration).
- When out_valid = 0, out_pc, out_pc_plus4, and out_instr are driven to 0 (NOP).
- out_pc_plus4 wraps modulo 2^B: 0xFFFFFFFC gives 0x00000000.
- flush: on that edge, count and both pointers go to 0. A push in the same cycle is dropped. A pop in the same cycle is a no-op. In the next cycle out_valid = 0.
- Priority: reset > flush > push/pop.
- Reset or flush in the middle of a stream discards every stored entry. No partial state survives.

## Timing
- Reset values: count = 0, out_valid = 0, out_pc = out_pc_plus4 = out_instr = 0, in_ready = 0 while reset is high and 1 in the first cycle after.
- Latency without bypass: a pair pushed at edge N is at the head and valid in cycle N+1 if the queue was empty.
- Throughput: 1 push and 1 pop per cycle sustained.
- in_ready depends only on registered count (plus reset). There is no combinational path from out_ready to in_ready.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count == 0, in_valid = 1, and flush = 0, the input pair is forwarded combinationally.
  - out_valid = 1, and out_pc/out_instr equal in_pc/in_instr in the same cycle.
  - If out_ready is also 1, nothing is stored and count stays 0.
  - If out_ready is 0, the pair is stored normally.
  - Zero-cycle latency when empty.
- FETCH_QUEUE_BYPASS_EN not defined: no input-to-output combinational path. Minimum latency is 1 cycle.

## Structure
- Shared package fetch_pkg:
  - INSTR_NOP = 32'h0000_0000
  - PC_INCR = 4
  - FETCH_QUEUE_DEPTH default
  - fetch_entry_t typedef {pc[B-1:0], instr[W-1:0]}
- Sub-module fetch_queue_mem: DEPTH×(B+W) register array with write port (we, waddr, wdata) on clk and asynchronous read port (raddr). No reset on the storage array, since contents are qualified by count.
- Top level holds the pointers, count, handshake logic, and the bypass mux.

## Test plan
- Reset then single push: in_pc=0x00000040, in_instr=0x8C220004 -> in cycle N+1: out_valid=1, out_pc=0x40, out_pc_plus4=0x44, count=1 (bypass off). With bypass on: out_valid=1 in the same cycle.
- Fill with out_ready=0: 4 pushes of pc 0x0, 0x4, 0x8, 0xC -> count=4, in_ready=0, and a fifth in_valid is not accepted. Then out_ready=1 pops in order 0x0, 0x4, 0x8, 0xC, and count returns to 0.
- Continuous push+pop at count=2 for 10 cycles -> count stays 2, and pointers wrap correctly with outputs in order.
- Flush with count=3 and simultaneous push of pc 0x100 -> next cycle: count=0, out_valid=0, and 0x100 is never output.
- out_pc=0xFFFFFFFC -> out_pc_plus4=0x00000000.
- Reset asserted with count=2 -> next cycle: count=0, out_valid=0, outputs 0. in_ready=0 during reset and 1 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the {pc, instr} entry type used by the
// fetch queue and its neighbours.
package fetch_pkg;

    localparam int FETCH_QUEUE_DEPTH = 4;
    localparam int FETCH_ADDR_W      = 32;
    localparam int FETCH_INSTR_W     = 32;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Not reset; validity is tracked by the queue count.
module fetch_queue_mem #(
    parameter int B     = 32,
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [B+W-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [B+W-1:0] rdata
);

    logic [B+W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Optional feature: define FETCH_QUEUE_BYPASS_EN for zero-latency forwarding when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int B     = 32,
    parameter int W     = 32,
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [B-1:0]  in_pc,
    input  logic [W-1:0]  in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [B-1:0]  out_pc,
    output logic [B-1:0]  out_pc_plus4,
    output logic [W-1:0]  out_instr,
    output logic [CW-1:0] count
);

    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [B+W-1:0] rdata_s;
    logic           head_valid_s;
    logic           byp_s;
    logic           push_s;
    logic           store_s;
    logic           deq_s;
    logic           we_s;
    logic [B-1:0]   out_pc_s;
    logic [W-1:0]   out_instr_s;

    assign in_ready     = (count_r < CW'(DEPTH)) && !reset;
    assign head_valid_s = (count_r != {CW{1'b0}});

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_s = (count_r == {CW{1'b0}}) && in_valid && !flush && !reset;
`else
    assign byp_s = 1'b0;
`endif

    assign out_valid = head_valid_s || byp_s;
    assign push_s    = in_valid && in_ready;
    // A bypassed pair taken by decode in the same cycle never enters storage.
    assign store_s   = push_s && !(byp_s && out_ready);
    assign deq_s     = head_valid_s && out_ready;
    assign we_s      = store_s && !flush && !reset;

    fetch_queue_mem #(
        .B     (B),
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Output mux: stored head, bypassed input, or NOP when nothing is valid
    always_comb begin
        out_pc_s    = {B{1'b0}};
        out_instr_s = W'(INSTR_NOP);
        if (head_valid_s) begin
            out_pc_s    = rdata_s[B+W-1:W];
            out_instr_s = rdata_s[W-1:0];
        end else if (byp_s) begin
            out_pc_s    = in_pc;
            out_instr_s = in_instr;
        end else begin
            out_pc_s    = {B{1'b0}};
            out_instr_s = W'(INSTR_NOP);
        end
    end

    assign out_pc       = out_pc_s;
    assign out_instr    = out_instr_s;
    assign out_pc_plus4 = out_valid ? (out_pc_s + B'(PC_INCR)) : {B{1'b0}};
    assign count        = count_r;

    // Pointer and occupancy state; reset and flush discard everything
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({store_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven vectors plus hand-written
// sequences, with a scoreboard queue of expected head entries.
module tb_fetch_queue;
    import fetch_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks;
    int errors;
    fetch_entry_t sb[$];

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        fl;
        int          exp_count;
    } vec_t;

    vec_t vecs[13];

    fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs against the
    // scoreboard, update the scoreboard for the coming edge, then clock.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        bit exp_ready, byp, exp_valid, pop, push;
        fetch_entry_t head;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_ready = (sb.size() < DEPTH);
        byp       = BYP && (sb.size() == 0) && iv && !fl;
        exp_valid = (sb.size() != 0) || byp;
        chk("count", 32'(count), 32'(sb.size()));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            head = (sb.size() != 0) ? sb[0] : '{pc: pc, instr: ins};
            chk("out_pc", out_pc, head.pc);
            chk("out_pc_plus4", out_pc_plus4, head.pc + 32'd4);
            chk("out_instr", out_instr, head.instr);
        end else begin
            chk("nop_pc", out_pc, 32'h0);
            chk("nop_pc_plus4", out_pc_plus4, 32'h0);
            chk("nop_instr", out_instr, 32'h0);
        end
        if (fl) begin
            sb.delete();
        end else if (!(byp && ordy)) begin
            pop  = exp_valid && ordy;
            push = iv && exp_ready;
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back('{pc: pc, instr: ins});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'h0;
        in_instr  = 32'h0;
        out_ready = 1'b0;

        vecs[0]  = '{1'b1, 32'h0000_0040, 32'h8C22_0004, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 0};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1111_0000, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b1, 32'h0000_0004, 32'h1111_0004, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b1, 32'h0000_0008, 32'h1111_0008, 1'b0, 1'b0, 3};
        vecs[5]  = '{1'b1, 32'h0000_000C, 32'h1111_000C, 1'b0, 1'b0, 4};
        vecs[6]  = '{1'b1, 32'h0000_0010, 32'h1111_0010, 1'b0, 1'b0, 4};
        vecs[7]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 3};
        vecs[8]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 2};
        vecs[9]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1};
        vecs[10] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 0};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 1'b0, 1};
        vecs[12] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 0};

        // Reset state
        #1;
        chk("in_ready_in_reset", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_pc", out_pc, 32'h0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("in_ready_in_reset2", 32'(in_ready), 32'h0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'h1);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
        end

        // Bypass-capable case: push with decode ready on an empty queue
        step(1'b1, 32'h0000_0080, 32'hAAAA_0080, 1'b1, 1'b0);
        chk("empty_push_pop_count", 32'(count), BYP ? 32'h0 : 32'h1);
        idle(1'b1);
        idle(1'b1);

        // Sustained push+pop at count 2, pointers wrap
        step(1'b1, 32'h0000_01F8, 32'hC000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_01FC, 32'hC000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h0000_0200 + 32'(4 * i), 32'hC100_0000 + 32'(i), 1'b1, 1'b0);
            chk("stream_count", 32'(count), 32'h2);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with count 3 and a simultaneous push of 0x100
        step(1'b1, 32'h0000_0300, 32'hF000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0304, 32'hF000_0001, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0308, 32'hF000_0002, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0100, 32'hF000_0100, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        idle(1'b1);
        idle(1'b1);

        // Reset with count 2
        step(1'b1, 32'h0000_0400, 32'hE000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0404, 32'hE000_0001, 1'b0, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("in_ready_reset_mid", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        sb.delete();
        chk("mid_reset_count", 32'(count), 32'h0);
        chk("mid_reset_out_valid", 32'(out_valid), 32'h0);
        chk("mid_reset_out_pc", out_pc, 32'h0);
        chk("mid_reset_out_pc_plus4", out_pc_plus4, 32'h0);
        chk("mid_reset_out_instr", out_instr, 32'h0);
        reset = 1'b0;
        #1;
        chk("in_ready_reset_release", 32'(in_ready), 32'h1);
        idle(1'b1);
        step(1'b1, 32'h0000_0500, 32'h1234_5678, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
